alu_result_monitor: RTL

- Receive-side companion to sync_arith_unit_4: samples each registered ALU result/status pair, tags it with the issuing opcode, and buffers it in a FWFT FIFO for downstream readout.
- Maintains saturating pass/error/drop counters and a sticky overflow flag.
- Sits directly on the ALU o_result/o_status outputs.
- Unlocks self-checking benches and on-chip result capture.

---
 rtl/alu_result_monitor.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_result_monitor.sv
// alu_result_monitor: tags ALU result/status samples with their opcode, buffers them in a FWFT FIFO
// and keeps saturating ok/error/drop counters. Optional macro: ALU_MON_ERR_FILTER_EN (keep error samples out of the FIFO).
module alu_result_monitor #(
  parameter int N     = 2,
  parameter int M     = 4,
  parameter int DEPTH = 8,
  parameter int CW    = 8
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_valid,
  input  logic [N-1:0]             i_op,
  input  logic [M-1:0]             i_result,
  input  logic [3:0]               i_status,
  input  logic                     i_rd_ready,
  output logic                     o_rd_valid,
  output logic [N+4+M-1:0]         o_rd_data,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic [CW-1:0]            o_ok_count,
  output logic [CW-1:0]            o_err_count,
  output logic [CW-1:0]            o_drop_count,
  output logic                     o_overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int DW = N + 4 + M;

  localparam logic [PW-1:0] PTR_ZERO  = {PW{1'b0}};
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [LW-1:0] LVL_ZERO  = {LW{1'b0}};
  localparam logic [LW-1:0] LVL_ONE   = LW'(1);
  localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_ALMOST = LW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
  localparam logic [DW-1:0] DATA_ZERO = {DW{1'b0}};

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_PARTIAL = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] value, input logic en);
    logic [CW-1:0] res;
    if (en && (value != CNT_MAX)) begin
      res = value + CW'(1);
    end else begin
      res = value;
    end
    return res;
  endfunction

  logic [DW-1:0] mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [LW-1:0] level_r;
  logic [1:0]    state_r;
  logic [DW-1:0] head_r;
  logic          rd_valid_r;
  logic [CW-1:0] ok_r;
  logic [CW-1:0] err_r;
  logic [CW-1:0] drop_r;
  logic          overflow_r;

  logic          pop_s;
  logic          cand_s;
  logic          push_s;
  logic          drop_s;
  logic          ok_inc_s;
  logic          err_inc_s;
  logic [DW-1:0] entry_s;
  logic [PW-1:0] rd_ptr_inc_s;
  logic [LW-1:0] level_nxt_s;
  logic [1:0]    state_nxt_s;
  logic [DW-1:0] head_nxt_s;

  // Push/pop/drop decisions and counter increment strobes for this cycle
  always_comb begin
    pop_s     = 1'b0;
    cand_s    = 1'b0;
    push_s    = 1'b0;
    drop_s    = 1'b0;
    ok_inc_s  = 1'b0;
    err_inc_s = 1'b0;
    entry_s   = {i_op, i_status, i_result};

    if (rd_valid_r && i_rd_ready) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end

`ifdef ALU_MON_ERR_FILTER_EN
    cand_s = i_valid & ~i_status[3];
`else
    cand_s = i_valid;
`endif

    if (cand_s && ((state_r != ST_FULL) || pop_s)) begin
      push_s = 1'b1;
      drop_s = 1'b0;
    end else if (cand_s) begin
      push_s = 1'b0;
      drop_s = 1'b1;
    end else begin
      push_s = 1'b0;
      drop_s = 1'b0;
    end

    ok_inc_s = push_s & ~i_status[3];
`ifdef ALU_MON_ERR_FILTER_EN
    // Errors are counted at the input, independent of FIFO space
    err_inc_s = i_valid & i_status[3];
`else
    err_inc_s = push_s & i_status[3];
`endif
  end

  // Next occupancy, FSM state and FWFT head entry
  always_comb begin
    rd_ptr_inc_s = rd_ptr_r + PTR_ONE;
    level_nxt_s  = level_r;
    state_nxt_s  = state_r;
    head_nxt_s   = head_r;

    case ({push_s, pop_s})
      2'b10:   level_nxt_s = level_r + LVL_ONE;
      2'b01:   level_nxt_s = level_r - LVL_ONE;
      default: level_nxt_s = level_r;
    endcase

    case (state_r)
      ST_EMPTY: begin
        if (push_s) begin
          state_nxt_s = ST_PARTIAL;
        end else begin
          state_nxt_s = ST_EMPTY;
        end
      end
      ST_PARTIAL: begin
        if (push_s && !pop_s && (level_r == LVL_ALMOST)) begin
          state_nxt_s = ST_FULL;
        end else if (pop_s && !push_s && (level_r == LVL_ONE)) begin
          state_nxt_s = ST_EMPTY;
        end else begin
          state_nxt_s = ST_PARTIAL;
        end
      end
      ST_FULL: begin
        if (pop_s && !push_s) begin
          state_nxt_s = ST_PARTIAL;
        end else begin
          state_nxt_s = ST_FULL;
        end
      end
      default: state_nxt_s = ST_EMPTY;
    endcase

    // With one entry left, a simultaneous push becomes the new head directly
    if (state_r == ST_EMPTY) begin
      if (push_s) begin
        head_nxt_s = entry_s;
      end else begin
        head_nxt_s = head_r;
      end
    end else if (pop_s) begin
      if (level_r == LVL_ONE) begin
        if (push_s) begin
          head_nxt_s = entry_s;
        end else begin
          head_nxt_s = head_r;
        end
      end else begin
        head_nxt_s = mem_r[rd_ptr_inc_s];
      end
    end else begin
      head_nxt_s = head_r;
    end
  end

  // Storage array write; reset blocks the write so a same-cycle push is never kept
  always_ff @(posedge i_clk) begin
    if (push_s && !i_reset) begin
      mem_r[wr_ptr_r] <= entry_s;
    end
  end

  // Pointers, occupancy, FSM, head register and statistics
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      level_r    <= LVL_ZERO;
      state_r    <= ST_EMPTY;
      head_r     <= DATA_ZERO;
      rd_valid_r <= 1'b0;
      ok_r       <= CNT_ZERO;
      err_r      <= CNT_ZERO;
      drop_r     <= CNT_ZERO;
      overflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_inc_s;
      end
      level_r    <= level_nxt_s;
      state_r    <= state_nxt_s;
      head_r     <= head_nxt_s;
      rd_valid_r <= (state_nxt_s != ST_EMPTY);
      ok_r       <= sat_inc(ok_r, ok_inc_s);
      err_r      <= sat_inc(err_r, err_inc_s);
      drop_r     <= sat_inc(drop_r, drop_s);
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign o_rd_valid   = rd_valid_r;
  assign o_rd_data    = head_r;
  assign o_level      = level_r;
  assign o_ok_count   = ok_r;
  assign o_err_count  = err_r;
  assign o_drop_count = drop_r;
  assign o_overflow   = overflow_r;

endmodule
